// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel window datapath.
//   ADDR_W_DEF / DIM_W_DEF : default address and image-dimension widths
//   wag_state_t            : traversal state of window_address_gen
//   FULL_LAST / COL_LAST   : final pixel index for 9-pixel and 3-pixel loads
package sobel_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DIM_W_DEF  = 10;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DONE   = 2'd2
    } wag_state_t;

    localparam logic [3:0] FULL_LAST = 4'd8;
    localparam logic [3:0] COL_LAST  = 4'd2;

endpackage

// File: rtl/window_address_gen_rise_detect.sv
// Registered rising-edge detector.
//   clk, n_rst : clock, asynchronous active-low reset
//   d          : level input
//   rise       : high while d is 1 and was 0 on the previous clock
module rise_detect (
    input  logic clk,
    input  logic n_rst,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/window_address_gen.sv
// Address generator for the 3x3 Sobel window.
// Tracks the window position, produces source read addresses for the
// window pixels and the destination write address of the window centre.
//
// Ports:
//   clk, n_rst                 clock, asynchronous active-low reset
//   load_initial               rising edge latches cfg_* and restarts
//   cfg_src_base/cfg_dst_base  image base addresses
//   cfg_width/cfg_height       image size in pixels
//   start_read / start_move    rising edge requests pixel / window advance
//   load_done/read_done/move_done  one-cycle response pulses
//   new_row                    with move_done when the window wrapped a row
//   all_done                   level, traversal finished
//   rd_addr / wr_addr          source pixel / destination centre address
//   pixel_idx, last_pixel, full_mode  pixel index within the current load
//   win_count                  windows completed (needs WAG_WIN_COUNT_EN,
//                              otherwise tied to 0)
//   dbg_state                  current traversal state
//
// Handshake: the controller holds a request line as a level; only its
// rising edge counts. The matching *_done pulse is registered and appears
// exactly one cycle after the edge. Priority load_initial > start_move >
// start_read; losing edges in the same cycle are dropped, and edges other
// than load_initial are ignored outside S_ACTIVE.
module window_address_gen
    import sobel_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DIM_W  = DIM_W_DEF
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 load_initial,
    input  logic [ADDR_W-1:0]    cfg_src_base,
    input  logic [ADDR_W-1:0]    cfg_dst_base,
    input  logic [DIM_W-1:0]     cfg_width,
    input  logic [DIM_W-1:0]     cfg_height,
    input  logic                 start_read,
    input  logic                 start_move,
    output logic                 load_done,
    output logic                 read_done,
    output logic                 move_done,
    output logic                 new_row,
    output logic                 all_done,
    output logic [ADDR_W-1:0]    rd_addr,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [3:0]           pixel_idx,
    output logic                 last_pixel,
    output logic                 full_mode,
    output logic [2*DIM_W-1:0]   win_count,
    output wag_state_t           dbg_state
);

    logic load_rise, read_rise, move_rise;

    rise_detect u_load_rd (.clk(clk), .n_rst(n_rst), .d(load_initial), .rise(load_rise));
    rise_detect u_read_rd (.clk(clk), .n_rst(n_rst), .d(start_read),   .rise(read_rise));
    rise_detect u_move_rd (.clk(clk), .n_rst(n_rst), .d(start_move),   .rise(move_rise));

    wag_state_t        state_q, state_d;
    logic [DIM_W-1:0]  width_q, width_d, height_q, height_d;
    logic [DIM_W-1:0]  row_q, row_d, col_q, col_d;
    logic [3:0]        idx_q, idx_d;
    logic              full_q, full_d;
    // row_base = src + row*width; dst_row_base = dst + (row+1)*width
    logic [ADDR_W-1:0] row_base_q, row_base_d, dst_row_base_q, dst_row_base_d;
    logic              load_done_d, read_done_d, move_done_d, new_row_d, all_done_d;
    logic [ADDR_W-1:0] width_ext;
    logic [3:0]        idx_last;

    assign width_ext = ADDR_W'(width_q);
    assign idx_last  = full_q ? FULL_LAST : COL_LAST;

    always_comb begin
        state_d        = state_q;
        width_d        = width_q;
        height_d       = height_q;
        row_d          = row_q;
        col_d          = col_q;
        idx_d          = idx_q;
        full_d         = full_q;
        row_base_d     = row_base_q;
        dst_row_base_d = dst_row_base_q;
        load_done_d    = 1'b0;
        read_done_d    = 1'b0;
        move_done_d    = 1'b0;
        new_row_d      = 1'b0;
        all_done_d     = all_done;

        if (load_rise) begin
            width_d        = cfg_width;
            height_d       = cfg_height;
            row_d          = '0;
            col_d          = '0;
            idx_d          = '0;
            full_d         = 1'b1;
            row_base_d     = cfg_src_base;
            dst_row_base_d = cfg_dst_base + ADDR_W'(cfg_width);
            load_done_d    = 1'b1;
            // Images smaller than one window have nothing to traverse.
            if (cfg_width < DIM_W'(3) || cfg_height < DIM_W'(3)) begin
                state_d    = S_DONE;
                all_done_d = 1'b1;
            end else begin
                state_d    = S_ACTIVE;
                all_done_d = 1'b0;
            end
        end else if (state_q == S_ACTIVE) begin
            if (move_rise) begin
                if (col_q < width_q - DIM_W'(3)) begin
                    col_d       = col_q + DIM_W'(1);
                    idx_d       = '0;
                    full_d      = 1'b0;
                    move_done_d = 1'b1;
                end else if (row_q < height_q - DIM_W'(3)) begin
                    col_d          = '0;
                    row_d          = row_q + DIM_W'(1);
                    idx_d          = '0;
                    full_d         = 1'b1;
                    row_base_d     = row_base_q + width_ext;
                    dst_row_base_d = dst_row_base_q + width_ext;
                    move_done_d    = 1'b1;
                    new_row_d      = 1'b1;
                end else begin
                    state_d    = S_DONE;
                    all_done_d = 1'b1;
                end
            end else if (read_rise) begin
                read_done_d = 1'b1;
                // Saturate at the last index; extra reads still answer.
                if (idx_q != idx_last) begin
                    idx_d = idx_q + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q        <= S_IDLE;
            width_q        <= '0;
            height_q       <= '0;
            row_q          <= '0;
            col_q          <= '0;
            idx_q          <= '0;
            full_q         <= 1'b0;
            row_base_q     <= '0;
            dst_row_base_q <= '0;
            load_done      <= 1'b0;
            read_done      <= 1'b0;
            move_done      <= 1'b0;
            new_row        <= 1'b0;
            all_done       <= 1'b0;
        end else begin
            state_q        <= state_d;
            width_q        <= width_d;
            height_q       <= height_d;
            row_q          <= row_d;
            col_q          <= col_d;
            idx_q          <= idx_d;
            full_q         <= full_d;
            row_base_q     <= row_base_d;
            dst_row_base_q <= dst_row_base_d;
            load_done      <= load_done_d;
            read_done      <= read_done_d;
            move_done      <= move_done_d;
            new_row        <= new_row_d;
            all_done       <= all_done_d;
        end
    end

    // Window-row offset and column offset of the current pixel, built from
    // shifts of width instead of a multiplier.
    logic [ADDR_W-1:0] row_off, col_off, rd_calc, wr_calc;

    always_comb begin
        row_off = '0;
        col_off = '0;
        if (full_q) begin
            case (idx_q)
                4'd3, 4'd4, 4'd5: row_off = width_ext;
                4'd6, 4'd7, 4'd8: row_off = width_ext << 1;
                default:          row_off = '0;
            endcase
            case (idx_q)
                4'd1, 4'd4, 4'd7: col_off = ADDR_W'(1);
                4'd2, 4'd5, 4'd8: col_off = ADDR_W'(2);
                default:          col_off = '0;
            endcase
        end else begin
            // New right-hand column sits two pixels right of col.
            case (idx_q)
                4'd1:    row_off = width_ext;
                4'd2:    row_off = width_ext << 1;
                default: row_off = '0;
            endcase
            col_off = ADDR_W'(2);
        end
        rd_calc = row_base_q + row_off + ADDR_W'(col_q) + col_off;
        wr_calc = dst_row_base_q + ADDR_W'(col_q) + ADDR_W'(1);
    end

    // Addresses read as zero until a configuration has been loaded.
    assign rd_addr    = (state_q == S_IDLE) ? '0 : rd_calc;
    assign wr_addr    = (state_q == S_IDLE) ? '0 : wr_calc;
    assign pixel_idx  = idx_q;
    assign last_pixel = (idx_q == idx_last);
    assign full_mode  = full_q;
    assign dbg_state  = state_q;

`ifdef WAG_WIN_COUNT_EN
    logic [2*DIM_W-1:0] win_q;
    logic               win_inc;

    // A window is finished on every successful move and on the final move.
    assign win_inc = move_done_d | (state_q == S_ACTIVE && state_d == S_DONE && !load_rise);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            win_q <= '0;
        end else if (load_rise) begin
            win_q <= '0;
        end else if (win_inc) begin
            win_q <= win_q + 1'b1;
        end
    end

    assign win_count = win_q;
`else
    assign win_count = '0;
`endif

endmodule
